// File: rtl/extend_8_16_pkg.sv
// Shared widths and the sign-extension function for the 8->16 extender.
// Pure combinational helper; no latency and no flow control.
package extend_8_16_pkg;

    localparam int EXT_IN_W  = 8;
    localparam int EXT_OUT_W = 16;

    // Replicates the operand's sign bit across the upper OUT_W-IN_W bits.
    function automatic logic [EXT_OUT_W-1:0] sign_ext(input logic [EXT_IN_W-1:0] v);
        return {{(EXT_OUT_W-EXT_IN_W){v[EXT_IN_W-1]}}, v};
    endfunction

endpackage

// File: rtl/extend_8_16_if.sv
// Bundles the operand and result buses of the extender for bench-side wiring.
// No handshake: one operand is presented and one result is returned per clock.
interface extend_8_16_if;
    import extend_8_16_pkg::*;

    logic [EXT_IN_W-1:0]  in1;
    logic [EXT_OUT_W-1:0] out1;

    modport master (output in1, input  out1);
    modport slave  (input  in1, output out1);
endinterface

// File: rtl/extend_8_16.sv
// Registered two's-complement sign extension of in1 to out1; latency 1 cycle.
// No backpressure: every rising edge out of reset captures in1.
module extend_8_16
    import extend_8_16_pkg::*;
#(
    parameter int IN_W  = EXT_IN_W,
    parameter int OUT_W = EXT_OUT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in1,
    output logic [OUT_W-1:0] out1
);

    logic [OUT_W-1:0] out1_d;
    logic [OUT_W-1:0] out1_q;

    // The package helper covers the shipped widths; other widths use the same rule inline.
    generate
        if (IN_W == EXT_IN_W && OUT_W == EXT_OUT_W) begin : g_pkg_ext
            assign out1_d = sign_ext(in1);
        end else if (OUT_W == IN_W) begin : g_same_w
            assign out1_d = in1;
        end else begin : g_gen_ext
            assign out1_d = {{(OUT_W-IN_W){in1[IN_W-1]}}, in1};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out1_q <= '0;
        end else begin
            out1_q <= out1_d;
        end
    end

    assign out1 = out1_q;

endmodule

// File: tb/tb_extend_8_16.sv
// Directed bench for extend_8_16: reset behaviour, hold, boundary table and full sweep.
module tb_extend_8_16;
    import extend_8_16_pkg::*;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    extend_8_16_if bus ();

    extend_8_16 #(.IN_W(EXT_IN_W), .OUT_W(EXT_OUT_W)) dut (
        .clk  (clk),
        .rst  (rst),
        .in1  (bus.in1),
        .out1 (bus.out1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  in_v;
        logic [15:0] exp_v;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    initial begin
        logic [15:0] prev_exp;
        n_tests = 0;
        n_fail  = 0;

        vecs[0] = '{8'hFF, 16'hFFFF};
        vecs[1] = '{8'h00, 16'h0000};
        vecs[2] = '{8'h01, 16'h0001};
        vecs[3] = '{8'h7E, 16'h007E};
        vecs[4] = '{8'h81, 16'hFF81};
        vecs[5] = '{8'hAA, 16'hFFAA};
        vecs[6] = '{8'h55, 16'h0055};
        vecs[7] = '{8'h7F, 16'h007F};
        vecs[8] = '{8'hFE, 16'hFFFE};
        vecs[9] = '{8'h80, 16'hFF80};

        // Reset from time zero with an unknown operand.
        rst     = 1'b0;
        bus.in1 = 'x;
        #2;
        check("reset_before_clk", bus.out1, 16'h0000);

        // A rising edge while reset is low must not load in1.
        bus.in1 = 8'h85;
        @(posedge clk); #1;
        check("edge_during_reset", bus.out1, 16'h0000);

        @(negedge clk);
        rst     = 1'b1;
        bus.in1 = 8'h80;
        #1;
        check("release_holds_zero", bus.out1, 16'h0000);
        @(posedge clk); #1;
        check("load_0x80", bus.out1, 16'hFF80);

        @(negedge clk);
        bus.in1 = 8'h7F;
        #1;
        check("hold_between_edges", bus.out1, 16'hFF80);
        @(posedge clk); #1;
        check("load_0x7F", bus.out1, 16'h007F);

        foreach (vecs[i]) begin
            @(negedge clk);
            bus.in1 = vecs[i].in_v;
            @(posedge clk); #1;
            check($sformatf("vec_%0d_in_%02h", i, vecs[i].in_v), bus.out1, vecs[i].exp_v);
        end

        // Asynchronous reset between edges while holding 0xFF80.
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("async_clear", bus.out1, 16'h0000);
        bus.in1 = 8'hC3;
        #1;
        rst = 1'b1;
        #1;
        check("hold_after_release", bus.out1, 16'h0000);
        @(posedge clk); #1;
        check("first_edge_after_rst", bus.out1, 16'hFFC3);

        // Exhaustive sweep; also confirm the previous result holds mid-cycle.
        prev_exp = 16'hFFC3;
        for (int v = 0; v < 256; v++) begin
            logic [7:0]  b;
            logic [15:0] e;
            b = v[7:0];
            e = 16'($signed(b));
            @(negedge clk);
            bus.in1 = b;
            #1;
            check($sformatf("sweep_hold_%02h", b), bus.out1, prev_exp);
            @(posedge clk); #1;
            check($sformatf("sweep_%02h", b), bus.out1, e);
            prev_exp = e;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
